// File: rtl/ram_ring_logger.sv
// ============================================================================
// Module      : ram_ring_logger
// Description : Circular sample buffer in a 16-bit dpRAM. Samples arrive on a
//               valid/ready stream; the oldest one is popped on rd_req.
//               Optional macro RING_OVERWRITE_EN: overwrite oldest when full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_ring_logger #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int BASE   = 0,
    parameter int DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       s_ready,
    input  logic                       rd_req,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic [15:0]                ovf_cnt,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [DATA_W-1:0]          ram_din,
    output logic                       ram_rd,
    output logic                       ram_wr,
    input  logic [DATA_W-1:0]          ram_dout
);

    localparam int                PW      = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] c_BASE  = ADDR_W'(BASE);
    localparam logic [PW:0]       c_DEPTH = (PW+1)'(DEPTH);
    localparam logic [PW-1:0]     c_PTR_1 = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [PW:0]         r_count;
    logic                r_rd_pend;
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_din;
    logic                r_ram_rd;
    logic                r_ram_wr;

    logic                w_empty;
    logic                w_full;
    logic                w_rd_go;
    logic                w_room;
    logic                w_s_ready;
    logic                w_wr_go;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [ADDR_W-1:0]   w_rd_addr;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);
    assign w_rd_go   = r_rd_pend && !w_empty;
`ifdef RING_OVERWRITE_EN
    assign w_room    = 1'b1;
`else
    assign w_room    = !w_full;
`endif
    // A serviceable read always beats a write, so it also withholds s_ready.
    assign w_s_ready = (r_state == ST_IDLE) && !w_rd_go && w_room;
    assign w_wr_go   = s_valid && w_s_ready;
    assign w_wr_addr = c_BASE + ADDR_W'(r_wr_ptr);
    assign w_rd_addr = c_BASE + ADDR_W'(r_rd_ptr);

`ifdef RING_OVERWRITE_EN
    logic [15:0] r_ovf_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_ram_rd   <= 1'b0;
            r_ram_wr   <= 1'b0;
`ifdef RING_OVERWRITE_EN
            r_ovf_cnt  <= '0;
`endif
        end else begin
            r_rd_valid <= 1'b0;
            if (rd_req && !r_rd_pend) begin
                r_rd_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_go) begin
                        r_state    <= ST_RD;
                        r_ram_rd   <= 1'b1;
                        r_ram_addr <= w_rd_addr;
                    end else if (w_wr_go) begin
                        r_state    <= ST_WR;
                        r_ram_wr   <= 1'b1;
                        r_ram_addr <= w_wr_addr;
                        r_ram_din  <= s_data;
                    end
                end
                ST_WR: begin
                    r_state  <= ST_IDLE;
                    r_ram_wr <= 1'b0;
                    r_wr_ptr <= r_wr_ptr + c_PTR_1;
`ifdef RING_OVERWRITE_EN
                    // Writing into a full ring drops the oldest sample.
                    if (w_full) begin
                        r_rd_ptr <= r_rd_ptr + c_PTR_1;
                        if (r_ovf_cnt != 16'hFFFF) begin
                            r_ovf_cnt <= r_ovf_cnt + 16'd1;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
`else
                    r_count  <= r_count + 1'b1;
`endif
                end
                ST_RD: begin
                    r_state    <= ST_IDLE;
                    r_ram_rd   <= 1'b0;
                    r_rd_data  <= ram_dout;
                    r_rd_valid <= 1'b1;
                    r_rd_ptr   <= r_rd_ptr + c_PTR_1;
                    r_count    <= r_count - 1'b1;
                    r_rd_pend  <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_ram_rd <= 1'b0;
                    r_ram_wr <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready  = w_s_ready;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign count    = r_count;
    assign empty    = w_empty;
    assign full     = w_full;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;
    assign ram_rd   = r_ram_rd;
    assign ram_wr   = r_ram_wr;
`ifdef RING_OVERWRITE_EN
    assign ovf_cnt  = r_ovf_cnt;
`else
    assign ovf_cnt  = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_ring_logger.sv
// ============================================================================
// Module      : tb_ram_ring_logger
// Description : Directed bench for ram_ring_logger (DEPTH=8, BASE=0x20) with a
//               negedge-acting RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_ring_logger;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int BASE   = 32;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_ready;
    logic              rd_req = 1'b0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [3:0]        count;
    logic              empty;
    logic              full;
    logic [15:0]       ovf_cnt;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_rd;
    logic              ram_wr;
    logic [DATA_W-1:0] ram_dout = '0;

    logic [DATA_W-1:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    ram_ring_logger #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE(BASE), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
        .count(count), .empty(empty), .full(full), .ovf_cnt(ovf_cnt),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_rd(ram_rd), .ram_wr(ram_wr),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_din;
        if (ram_rd) ram_dout <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        rd_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Offers one sample, then checks the WR-cycle strobes and returns in IDLE.
    task automatic push(input logic [15:0] d, input logic [7:0] exp_addr);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        chk("push_ready", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        chk("wr_strobe", 32'(ram_wr), 32'd1);
        chk("wr_addr", 32'(ram_addr), 32'(exp_addr));
        chk("wr_din", 32'(ram_din), 32'(d));
        chk("wr_no_rd", 32'(ram_rd), 32'd0);
        tick();
    endtask

    // Waits for rd_valid, remembering the address strobed during RD.
    task automatic wait_rd(input logic [15:0] exp_data, input logic [7:0] exp_addr);
        int n = 0;
        logic [7:0] a = 8'h00;
        while (!rd_valid && n < 50) begin
            if (ram_rd) begin
                a = ram_addr;
                chk("rd_no_wr", 32'(ram_wr), 32'd0);
            end
            tick();
            n++;
        end
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_addr", 32'(a), 32'(exp_addr));
        chk("rd_data", 32'(rd_data), 32'(exp_data));
    endtask

    task automatic pop(input logic [15:0] exp_data, input logic [7:0] exp_addr);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        wait_rd(exp_data, exp_addr);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;

        // 1: reset values, single push/pop
        tick();
        do_reset();
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_ram_rd", 32'(ram_rd), 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ovf", 32'(ovf_cnt), 32'd0);
        push(16'h1234, 8'(BASE));
        chk("t1_count1", 32'(count), 32'd1);
        pop(16'h1234, 8'(BASE));
        chk("t1_count0", 32'(count), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);
        held = rd_data;
        tick();
        chk("t1_valid_pulse", 32'(rd_valid), 32'd0);
        chk("t1_data_hold", 32'(rd_data), 32'(held));

`ifdef RING_OVERWRITE_EN
        // 5: overwrite oldest when full
        do_reset();
        for (int i = 0; i < 10; i++) push(16'(i), 8'(BASE + (i % DEPTH)));
        chk("t5_ovf", 32'(ovf_cnt), 32'd2);
        chk("t5_count", 32'(count), 32'd8);
        chk("t5_full", 32'(full), 32'd1);
        for (int i = 2; i < 10; i++) pop(16'(i), 8'(BASE + (i % DEPTH)));
        chk("t5_empty", 32'(empty), 32'd1);
`else
        // 2: fill to full, backpressure, drain in order
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(16'hA000 + 16'(i), 8'(BASE + i));
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count", 32'(count), 32'd8);
        s_valid = 1'b1;
        s_data  = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            chk("t2_backpressure", 32'(s_ready), 32'd0);
            tick();
            chk("t2_no_wr", 32'(ram_wr), 32'd0);
        end
        s_valid = 1'b0;
        chk("t2_ovf_zero", 32'(ovf_cnt), 32'd0);
        for (int i = 0; i < DEPTH; i++) pop(16'hA000 + 16'(i), 8'(BASE + i));
        chk("t2_empty", 32'(empty), 32'd1);
        chk("t2_count0", 32'(count), 32'd0);
`endif

        // 3: pointer wrap 7 -> 0
        do_reset();
        for (int i = 0; i < 5; i++) push(16'hB000 + 16'(i), 8'(BASE + i));
        for (int i = 0; i < 5; i++) pop(16'hB000 + 16'(i), 8'(BASE + i));
        for (int i = 0; i < 6; i++) push(16'hC000 + 16'(i), 8'(BASE + ((5 + i) % DEPTH)));
        chk("t3_count", 32'(count), 32'd6);
        for (int i = 0; i < 6; i++) pop(16'hC000 + 16'(i), 8'(BASE + ((5 + i) % DEPTH)));
        chk("t3_empty", 32'(empty), 32'd1);

        // 4: read request while empty waits for the next write (ptrs now at 3)
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_no_valid", 32'(rd_valid), 32'd0);
            chk("t4_no_rd", 32'(ram_rd), 32'd0);
            tick();
        end
        push(16'hBEEF, 8'(BASE + 3));
        wait_rd(16'hBEEF, 8'(BASE + 3));
        chk("t4_empty", 32'(empty), 32'd1);

        // 6: reset asserted during RD
        do_reset();
        push(16'h5A5A, 8'(BASE));
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        for (int n = 0; n < 20 && !ram_rd; n++) tick();
        chk("t6_in_rd", 32'(ram_rd), 32'd1);
        rst = 1'b1;
        tick();
        chk("t6_no_valid", 32'(rd_valid), 32'd0);
        chk("t6_ram_rd", 32'(ram_rd), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        rst = 1'b0;
        tick();
        tick();
        chk("t6_still_no_valid", 32'(rd_valid), 32'd0);
        chk("t6_idle_no_rd", 32'(ram_rd), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
